// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-RAM arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CPU,
        CAM
    } arb_state_t;

    localparam int DEF_BURST_LEN    = 8;
    localparam int DEF_CAM_MAX_WAIT = 16;
    localparam int CNT_W            = 8;
    localparam int PERF_W           = 32;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Clear wins over increment so a clear in the same cycle never leaves a stale count.
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != MAX)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: CPU memory stage has priority, camera writer gets bounded bursts
// and is promoted after CAM_MAX_WAIT cycles. DMEM_ARB_PERF_EN adds perf counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int BURST_LEN    = DEF_BURST_LEN,
    parameter int CAM_MAX_WAIT = DEF_CAM_MAX_WAIT,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    output logic [DW-1:0]     cpu_rdata,
    output logic              cpu_stall,
    input  logic              cam_valid,
    input  logic [AW-1:0]     cam_addr,
    input  logic [DW-1:0]     cam_wdata,
    input  logic              cam_last,
    output logic              cam_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_cam_beats
`endif
);

    localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(CAM_MAX_WAIT);
    localparam logic [CNT_W-1:0] BEAT_MAX  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BURST_LEN - 1);

    arb_state_t       state_reg;
    arb_state_t       state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] beat_cnt;
    logic             cpu_grant;
    logic             cam_grant;
    logic             promote;
    logic             burst_done;
    logic             rd_capture_reg;
    logic [DW-1:0]    rdata_hold_reg;

    assign promote    = cam_valid && (wait_cnt == WAIT_MAX);
    // beat_cnt holds beats already taken, so this beat is the last when it sits at BURST_LEN-1.
    assign burst_done = cam_last || (beat_cnt >= BEAT_LAST);

    always_comb begin
        state_next = state_reg;
        cpu_grant  = 1'b0;
        cam_grant  = 1'b0;
        cpu_stall  = 1'b0;
        // reset is active-low; while it is asserted every grant is suppressed.
        if (reset) begin
            case (state_reg)
                CAM: begin
                    cpu_stall  = cpu_req;
                    cam_grant  = cam_valid;
                    state_next = (cam_valid && !burst_done) ? CAM : IDLE;
                end
                default: begin
                    if (cam_valid && (promote || !cpu_req)) begin
                        cam_grant  = 1'b1;
                        cpu_stall  = cpu_req;
                        state_next = burst_done ? IDLE : CAM;
                    end else if (cpu_req) begin
                        cpu_grant  = 1'b1;
                        state_next = CPU;
                    end else begin
                        state_next = IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cam_ready = 1'b0;
        if (cam_grant) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cam_addr;
            mem_wdata = cam_wdata;
            cam_ready = 1'b1;
        end else if (cpu_grant) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            rd_capture_reg <= 1'b0;
            rdata_hold_reg <= '0;
        end else begin
            state_reg      <= state_next;
            rd_capture_reg <= cpu_grant && !cpu_we;
            if (rd_capture_reg) begin
                rdata_hold_reg <= mem_rdata;
            end
        end
    end

    // Fresh RAM data passes straight through in the cycle after a load, then is held.
    assign cpu_rdata = rd_capture_reg ? mem_rdata : rdata_hold_reg;

    sat_counter #(
        .W   (CNT_W),
        .MAX (WAIT_MAX)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (cam_valid && !cam_ready),
        .clr   (!cam_valid || cam_ready),
        .count (wait_cnt)
    );

    sat_counter #(
        .W   (CNT_W),
        .MAX (BEAT_MAX)
    ) u_beat_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (cam_ready),
        .clr   (state_next == IDLE),
        .count (beat_cnt)
    );

`ifdef DMEM_ARB_PERF_EN
    logic [1:0]        perf_inc;
    logic [PERF_W-1:0] perf_cnt [2];

    assign perf_inc = {cam_ready, cpu_stall};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            sat_counter #(
                .W (PERF_W)
            ) u_perf (
                .clk   (clk),
                .rst_n (reset),
                .inc   (perf_inc[gi]),
                .clr   (1'b0),
                .count (perf_cnt[gi])
            );
        end
    endgenerate

    assign perf_stall_cycles = perf_cnt[0];
    assign perf_cam_beats    = perf_cnt[1];
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector tables, hand-written reset sequence,
// and a load-data scoreboard. Perf counters are checked when DMEM_ARB_PERF_EN is set.
module tb_dmem_arbiter;

    localparam int OWN_NONE = 0;
    localparam int OWN_CPU  = 1;
    localparam int OWN_CAM  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cam_valid;
    logic [31:0] cam_addr;
    logic [31:0] cam_wdata;
    logic        cam_last;
    logic        cam_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_cam_beats;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(
        .BURST_LEN    (8),
        .CAM_MAX_WAIT (16),
        .AW           (32),
        .DW           (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cam_valid (cam_valid),
        .cam_addr  (cam_addr),
        .cam_wdata (cam_wdata),
        .cam_last  (cam_last),
        .cam_ready (cam_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_cam_beats    (perf_cam_beats)
`endif
    );

    // Single-port RAM with one-cycle read latency.
    logic [31:0] ram [0:4095];
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr[13:2]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[13:2]];
    end

    typedef struct {
        string       name;
        logic        cpu_req;
        logic        cpu_we;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic        cam_valid;
        logic [31:0] cam_addr;
        logic [31:0] cam_wdata;
        logic        cam_last;
        int          owner;
        logic        exp_stall;
    } vec_t;

    vec_t        main_tbl[$];
    vec_t        starve_tbl[$];
    logic [31:0] rd_q[$];
    logic [31:0] shadow [logic [31:0]];
    logic [31:0] exp_hold;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic vec_t mk(string name, logic creq, logic cwe, logic [31:0] caddr,
                                logic [31:0] cwd, logic vld, logic [31:0] vaddr,
                                logic [31:0] vwd, logic vlast, int owner, logic stall);
        vec_t v;
        v.name = name;       v.cpu_req = creq;   v.cpu_we = cwe;
        v.cpu_addr = caddr;  v.cpu_wdata = cwd;  v.cam_valid = vld;
        v.cam_addr = vaddr;  v.cam_wdata = vwd;  v.cam_last = vlast;
        v.owner = owner;     v.exp_stall = stall;
        return v;
    endfunction

    task automatic check(string what, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", what, act, exp);
        end
    endtask

    task automatic check_bit(string what, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", what, act, exp);
        end
    endtask

    // Entered just after a rising edge; checks at the falling edge; leaves just after the next rising edge.
    task automatic run_vec(vec_t v);
        logic        exp_en;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        cpu_req   = v.cpu_req;   cpu_we    = v.cpu_we;
        cpu_addr  = v.cpu_addr;  cpu_wdata = v.cpu_wdata;
        cam_valid = v.cam_valid; cam_addr  = v.cam_addr;
        cam_wdata = v.cam_wdata; cam_last  = v.cam_last;
        @(negedge clk);
        if (rd_q.size() != 0) exp_hold = rd_q.pop_front();
        exp_en   = (v.owner != OWN_NONE);
        exp_we   = (v.owner == OWN_CAM) || ((v.owner == OWN_CPU) && v.cpu_we);
        exp_addr = (v.owner == OWN_CAM) ? v.cam_addr : v.cpu_addr;
        exp_wd   = (v.owner == OWN_CAM) ? v.cam_wdata : v.cpu_wdata;
        check_bit({v.name, ".mem_en"}, mem_en, exp_en);
        check_bit({v.name, ".cam_ready"}, cam_ready, v.owner == OWN_CAM);
        check_bit({v.name, ".cpu_stall"}, cpu_stall, v.exp_stall);
        check({v.name, ".cpu_rdata"}, cpu_rdata, exp_hold);
        if (exp_en) begin
            check_bit({v.name, ".mem_we"}, mem_we, exp_we);
            check({v.name, ".mem_addr"}, mem_addr, exp_addr);
            if (exp_we) begin
                check({v.name, ".mem_wdata"}, mem_wdata, exp_wd);
                shadow[exp_addr] = exp_wd;
            end else begin
                rd_q.push_back(shadow.exists(exp_addr) ? shadow[exp_addr] : 32'h0);
            end
        end
        $display("%0t %s en=%0b we=%0b addr=%h rdy=%0b stall=%0b rdata=%h",
                 $time, v.name, mem_en, mem_we, mem_addr, cam_ready, cpu_stall, cpu_rdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // CPU only: store then load, data visible the cycle after the load grant.
        main_tbl.push_back(mk("st40", 1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0, OWN_CPU, 0));
        main_tbl.push_back(mk("ld40", 1, 0, 32'h40, 0, 0, 0, 0, 0, OWN_CPU, 0));
        main_tbl.push_back(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, OWN_NONE, 0));
        main_tbl.push_back(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, OWN_NONE, 0));
        // CAM only: 8-beat burst, IDLE cycle re-grants the camera when the CPU is quiet.
        for (int i = 0; i < 9; i++) begin
            main_tbl.push_back(mk($sformatf("cam%0d", i), 0, 0, 0, 0, 1,
                                  32'h1000 + 32'(4 * i), 32'hCA000000 + 32'(i), 0, OWN_CAM, 0));
        end
        // CPU load arrives mid-burst; cam_last on beat 3 ends the burst, CPU served next.
        main_tbl.push_back(mk("last_b2", 1, 0, 32'h1004, 0, 1, 32'h1024, 32'hCA000009, 0, OWN_CAM, 1));
        main_tbl.push_back(mk("last_b3", 1, 0, 32'h1004, 0, 1, 32'h1028, 32'hCA00000A, 1, OWN_CAM, 1));
        main_tbl.push_back(mk("last_srv", 1, 0, 32'h1004, 0, 1, 32'h102C, 32'hCA00000B, 0, OWN_CPU, 0));
        main_tbl.push_back(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, OWN_NONE, 0));
        // cam_valid drops mid-burst: no grant that cycle, CPU still stalled, then served.
        main_tbl.push_back(mk("drop_b1", 0, 0, 0, 0, 1, 32'h1100, 32'hB0000001, 0, OWN_CAM, 0));
        main_tbl.push_back(mk("drop_b2", 0, 0, 0, 0, 1, 32'h1104, 32'hB0000002, 0, OWN_CAM, 0));
        main_tbl.push_back(mk("drop_gap", 1, 1, 32'h44, 32'h12345678, 0, 32'h1108, 0, 0, OWN_NONE, 1));
        main_tbl.push_back(mk("drop_srv", 1, 1, 32'h44, 32'h12345678, 0, 32'h1108, 0, 0, OWN_CPU, 0));
        main_tbl.push_back(mk("ld44", 1, 0, 32'h44, 0, 0, 0, 0, 0, OWN_CPU, 0));
        main_tbl.push_back(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, OWN_NONE, 0));
        // Four beats of a burst that gets reset on beat 5.
        for (int i = 0; i < 4; i++) begin
            main_tbl.push_back(mk($sformatf("rb%0d", i + 1), 0, 0, 0, 0, 1,
                                  32'h3000 + 32'(4 * i), 32'hC0DE0000 + 32'(i + 1), 0, OWN_CAM, 0));
        end

        // Starvation: CPU loads every cycle, camera promoted after 16 waiting cycles.
        for (int i = 0; i < 16; i++) begin
            starve_tbl.push_back(mk($sformatf("sw%0d", i), 1, 0, 32'h40, 0, 1,
                                    32'h2000, 32'hF0000000, 0, OWN_CPU, 0));
        end
        for (int k = 0; k < 8; k++) begin
            starve_tbl.push_back(mk($sformatf("sb%0d", k), 1, 0, 32'h40, 0, 1,
                                    32'h2000 + 32'(4 * k), 32'hF0000000 + 32'(k), 0, OWN_CAM, 1));
        end
        starve_tbl.push_back(mk("s_srv", 1, 0, 32'h40, 0, 1, 32'h2020, 32'hF0000008, 0, OWN_CPU, 0));
        starve_tbl.push_back(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, OWN_NONE, 0));

        // Reset held with both requesters active: every output must stay 0.
        exp_hold  = 32'h0;
        reset     = 1'b0;
        cpu_req   = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = 32'h0;
        cam_valid = 1'b1; cam_addr = 32'h1000; cam_wdata = 32'h0; cam_last = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_bit("rst.mem_en", mem_en, 1'b0);
            check_bit("rst.cam_ready", cam_ready, 1'b0);
            check_bit("rst.cpu_stall", cpu_stall, 1'b0);
            check("rst.cpu_rdata", cpu_rdata, 32'h0);
            $display("%0t reset en=%0b rdy=%0b stall=%0b rdata=%h",
                     $time, mem_en, cam_ready, cpu_stall, cpu_rdata);
        end
        @(posedge clk);
        #1;
        cpu_req   = 1'b0;
        cam_valid = 1'b0;
        reset     = 1'b1;

        foreach (main_tbl[i]) run_vec(main_tbl[i]);

        // Beat 5 in flight, then reset drops cam_ready and mem_en without waiting for a clock.
        cpu_req   = 1'b0;
        cam_valid = 1'b1; cam_addr = 32'h3010; cam_wdata = 32'hC0DE0005; cam_last = 1'b0;
        #1;
        check_bit("rst_mid.ready_before", cam_ready, 1'b1);
        reset = 1'b0;
        #1;
        check_bit("rst_mid.cam_ready", cam_ready, 1'b0);
        check_bit("rst_mid.mem_en", mem_en, 1'b0);
        $display("%0t reset_mid rdy=%0b en=%0b", $time, cam_ready, mem_en);
        cam_valid = 1'b0;
        @(posedge clk);
        #1;
        rd_q.delete();
        exp_hold = 32'h0;
        check("rst_mid.cpu_rdata", cpu_rdata, 32'h0);
`ifdef DMEM_ARB_PERF_EN
        check("rst_mid.perf_stall", perf_stall_cycles, 32'd0);
        check("rst_mid.perf_beats", perf_cam_beats, 32'd0);
`endif
        reset = 1'b1;

        foreach (starve_tbl[i]) run_vec(starve_tbl[i]);

`ifdef DMEM_ARB_PERF_EN
        check("perf_stall_cycles", perf_stall_cycles, 32'd8);
        check("perf_cam_beats", perf_cam_beats, 32'd8);
        $display("%0t perf stall=%0d beats=%0d", $time, perf_stall_cycles, perf_cam_beats);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
